// File: rtl/elgamal_encrypting_entity.sv
// ElGamal encryption engine: takes key (p, g, h), then per message (m, k) emits c1 = g^k mod p, c2 = m*h^k mod p.
// Optional operand range checks are enabled by defining ELGAMAL_ENC_RANGE_CHECK_EN.
module elgamal_encrypting_entity #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] input_p_tdata,
    input  logic [SIZE-1:0] input_g_tdata,
    input  logic [SIZE-1:0] input_h_tdata,
    input  logic            input_p_tvalid,
    input  logic            input_g_tvalid,
    input  logic            input_h_tvalid,
    output logic            input_p_tready,
    output logic            input_g_tready,
    output logic            input_h_tready,
    input  logic [SIZE-1:0] input_m_tdata,
    input  logic [SIZE-1:0] input_k_tdata,
    input  logic            input_m_tvalid,
    input  logic            input_k_tvalid,
    output logic            input_m_tready,
    output logic            input_k_tready,
    output logic [SIZE-1:0] output_c1_tdata,
    output logic [SIZE-1:0] output_c2_tdata,
    output logic            output_c1_tvalid,
    output logic            output_c2_tvalid,
    input  logic            output_c1_tready,
    input  logic            output_c2_tready,
    output logic            output_error
);
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] BIT_MAX = CW'(SIZE - 1);

    localparam logic [2:0] ST_KEY   = 3'd0;
    localparam logic [2:0] ST_MSG   = 3'd1;
    localparam logic [2:0] ST_EXP   = 3'd2;
    localparam logic [2:0] ST_FINAL = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    // One MSB-first shift-add step of a*b mod p; acc stays below p so SIZE+1 bits never overflow.
    function automatic logic [SIZE:0] mod_step(input logic [SIZE:0] acc, input logic [SIZE-1:0] a,
                                               input logic b_bit, input logic [SIZE-1:0] p);
        logic [SIZE:0] t;
        logic [SIZE:0] pe;
        pe = {1'b0, p};
        t  = {acc[SIZE-1:0], 1'b0};
        t  = (t >= pe) ? (t - pe) : t;
        t  = b_bit ? (t + {1'b0, a}) : t;
        t  = (t >= pe) ? (t - pe) : t;
        return t;
    endfunction

    logic [2:0]      state_r;
    logic [SIZE-1:0] p_r, g_r, h_r, m_r, k_r;
    logic [SIZE-1:0] rg_r, rh_r;
    logic [SIZE:0]   acc_g_r, acc_h_r;
    logic [CW-1:0]   bit_cnt_r, idx_r;
    logic            sq_phase_r, fin_done_r, err_r, err_out_r;
    logic [SIZE-1:0] c1_data_r, c2_data_r;
    logic            c1_valid_r, c2_valid_r;

    logic            key_take_s, msg_take_s, msg_err_s, last_bit_s;
    logic            b_g_bit_s, b_h_bit_s, c1_left_s, c2_left_s;
    logic [SIZE-1:0] a_h_s;
    logic [SIZE:0]   step_g_s, step_h_s;

    assign key_take_s = (state_r == ST_KEY) & input_p_tvalid & input_g_tvalid & input_h_tvalid;
    assign msg_take_s = (state_r == ST_MSG) & input_m_tvalid & input_k_tvalid;
    assign last_bit_s = (bit_cnt_r == {CW{1'b0}});
    assign c1_left_s  = c1_valid_r & ~output_c1_tready;
    assign c2_left_s  = c2_valid_r & ~output_c2_tready;

`ifdef ELGAMAL_ENC_RANGE_CHECK_EN
    logic key_bad_r;
    assign msg_err_s = key_bad_r | (input_m_tdata >= p_r) | (input_k_tdata == {SIZE{1'b0}});
`else
    assign msg_err_s = 1'b0;
`endif

    // Operand selection: squares in EXP square phase, by g/h in multiply phase, m*rh in FINAL.
    always_comb begin
        a_h_s     = rh_r;
        b_g_bit_s = 1'b0;
        b_h_bit_s = 1'b0;
        if (state_r == ST_FINAL) begin
            a_h_s     = m_r;
            b_h_bit_s = rh_r[bit_cnt_r];
        end else if (sq_phase_r) begin
            b_g_bit_s = rg_r[bit_cnt_r];
            b_h_bit_s = rh_r[bit_cnt_r];
        end else begin
            b_g_bit_s = g_r[bit_cnt_r];
            b_h_bit_s = h_r[bit_cnt_r];
        end
    end

    assign step_g_s = mod_step(acc_g_r, rg_r, b_g_bit_s, p_r);
    assign step_h_s = mod_step(acc_h_r, a_h_s, b_h_bit_s, p_r);

    // Main control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_KEY;
            p_r        <= {SIZE{1'b0}};
            g_r        <= {SIZE{1'b0}};
            h_r        <= {SIZE{1'b0}};
            m_r        <= {SIZE{1'b0}};
            k_r        <= {SIZE{1'b0}};
            rg_r       <= {SIZE{1'b0}};
            rh_r       <= {SIZE{1'b0}};
            acc_g_r    <= {(SIZE+1){1'b0}};
            acc_h_r    <= {(SIZE+1){1'b0}};
            bit_cnt_r  <= {CW{1'b0}};
            idx_r      <= {CW{1'b0}};
            sq_phase_r <= 1'b0;
            fin_done_r <= 1'b0;
            err_r      <= 1'b0;
            err_out_r  <= 1'b0;
            c1_data_r  <= {SIZE{1'b0}};
            c2_data_r  <= {SIZE{1'b0}};
            c1_valid_r <= 1'b0;
            c2_valid_r <= 1'b0;
`ifdef ELGAMAL_ENC_RANGE_CHECK_EN
            key_bad_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_KEY: begin
                    if (key_take_s) begin
                        p_r     <= input_p_tdata;
                        g_r     <= input_g_tdata;
                        h_r     <= input_h_tdata;
                        state_r <= ST_MSG;
`ifdef ELGAMAL_ENC_RANGE_CHECK_EN
                        key_bad_r <= (input_p_tdata < SIZE'(2)) | (input_g_tdata >= input_p_tdata) |
                                     (input_h_tdata >= input_p_tdata);
`endif
                    end else begin
                        state_r <= ST_KEY;
                    end
                end
                ST_MSG: begin
                    if (msg_take_s) begin
                        m_r        <= input_m_tdata;
                        k_r        <= input_k_tdata;
                        rg_r       <= {{(SIZE-1){1'b0}}, 1'b1};
                        rh_r       <= {{(SIZE-1){1'b0}}, 1'b1};
                        acc_g_r    <= {(SIZE+1){1'b0}};
                        acc_h_r    <= {(SIZE+1){1'b0}};
                        bit_cnt_r  <= BIT_MAX;
                        idx_r      <= BIT_MAX;
                        sq_phase_r <= 1'b1;
                        fin_done_r <= 1'b0;
                        err_r      <= msg_err_s;
                        state_r    <= msg_err_s ? ST_FINAL : ST_EXP;
                    end else begin
                        state_r <= ST_MSG;
                    end
                end
                ST_EXP: begin
                    if (last_bit_s) begin
                        acc_g_r   <= {(SIZE+1){1'b0}};
                        acc_h_r   <= {(SIZE+1){1'b0}};
                        bit_cnt_r <= BIT_MAX;
                        if (sq_phase_r) begin
                            rg_r       <= step_g_s[SIZE-1:0];
                            rh_r       <= step_h_s[SIZE-1:0];
                            sq_phase_r <= 1'b0;
                        end else begin
                            // Multiply phase always runs; its result is kept only for set exponent bits.
                            if (k_r[idx_r]) begin
                                rg_r <= step_g_s[SIZE-1:0];
                                rh_r <= step_h_s[SIZE-1:0];
                            end else begin
                                rg_r <= rg_r;
                                rh_r <= rh_r;
                            end
                            sq_phase_r <= 1'b1;
                            if (idx_r == {CW{1'b0}}) begin
                                state_r <= ST_FINAL;
                            end else begin
                                idx_r <= idx_r - {{(CW-1){1'b0}}, 1'b1};
                            end
                        end
                    end else begin
                        acc_g_r   <= step_g_s;
                        acc_h_r   <= step_h_s;
                        bit_cnt_r <= bit_cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_FINAL: begin
                    if (err_r || fin_done_r) begin
                        c1_data_r  <= err_r ? {SIZE{1'b0}} : rg_r;
                        c2_data_r  <= err_r ? {SIZE{1'b0}} : rh_r;
                        c1_valid_r <= 1'b1;
                        c2_valid_r <= 1'b1;
                        err_out_r  <= err_r;
                        fin_done_r <= 1'b0;
                        state_r    <= ST_OUT;
                    end else if (last_bit_s) begin
                        rh_r       <= step_h_s[SIZE-1:0];
                        fin_done_r <= 1'b1;
                    end else begin
                        acc_h_r   <= step_h_s;
                        bit_cnt_r <= bit_cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_OUT: begin
                    c1_valid_r <= c1_left_s;
                    c2_valid_r <= c2_left_s;
                    if (!c1_left_s && !c2_left_s) begin
                        err_out_r <= 1'b0;
                        state_r   <= ST_MSG;
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                default: begin
                    state_r <= ST_KEY;
                end
            endcase
        end
    end

    assign input_p_tready   = (state_r == ST_KEY) & ~rst;
    assign input_g_tready   = (state_r == ST_KEY) & ~rst;
    assign input_h_tready   = (state_r == ST_KEY) & ~rst;
    assign input_m_tready   = (state_r == ST_MSG) & ~rst;
    assign input_k_tready   = (state_r == ST_MSG) & ~rst;
    assign output_c1_tdata  = c1_data_r;
    assign output_c2_tdata  = c2_data_r;
    assign output_c1_tvalid = c1_valid_r;
    assign output_c2_tvalid = c2_valid_r;
    assign output_error     = err_out_r;

endmodule
